// File: rtl/even_count_checker_if.sv
// even_count_checker_if: bus between the even-counter monitor and its
// surroundings.
//   count_in   : monitored count bus (driven by master, sampled every cycle)
//   clear_err  : synchronous clear of err_count (driven by master)
//   locked     : checker is in LOCKED (driven by slave)
//   err_pulse  : one-cycle pulse per violating sample (driven by slave)
//   err_count  : saturating violation counter (driven by slave)
//   wrap_count : saturating wrap counter, LOCKED only (driven by slave)
//   expected   : next advancing value the checker expects (driven by slave)
interface even_count_checker_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] count_in;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output count_in, clear_err,
        input  locked, err_pulse, err_count, wrap_count, expected
    );

    modport slave (
        input  count_in, clear_err,
        output locked, err_pulse, err_count, wrap_count, expected
    );
endinterface

// File: rtl/even_count_checker.sv
// even_count_checker: monitors an even counter's count bus and checks that it
// steps 0, STEP, 2*STEP, ... (mod 2^WIDTH), with optional holds. Reports lock,
// pulses on each violation, and keeps saturating error and wrap counters.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low; clears all state
//   bus   : even_count_checker_if.slave (count_in, clear_err in;
//           locked, err_pulse, err_count, wrap_count, expected out)
module even_count_checker #(
    parameter int WIDTH      = 3,
    parameter int STEP       = 2,
    parameter int LOCK_N     = 2,
    parameter int ALLOW_HOLD = 1,
    parameter int CNT_W      = 8
) (
    input logic                 clk,
    input logic                 reset,
    even_count_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [3:0]       LOCK_W = 4'(LOCK_N);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       match_cnt;

    logic [WIDTH-1:0] adv_val;
    logic             is_odd;
    logic             is_adv;
    logic             is_hold;
    logic             err_now;
    logic             wrap_now;
    logic [CNT_W-1:0] err_base;

    // Sample classification; ODD overrides everything, then ADV, then HOLD.
    always_comb begin
        adv_val  = prev + STEP_W;
        is_odd   = bus.count_in[0];
        is_adv   = !is_odd && (bus.count_in == adv_val);
        is_hold  = !is_odd && !is_adv && (ALLOW_HOLD != 0) && (bus.count_in == prev);
        // Only ODD (any state) and BAD in LOCKED are errors; BAD in ACQUIRE resyncs silently.
        err_now  = is_odd || ((state == LOCKED) && !is_adv && !is_hold);
        wrap_now = (state == LOCKED) && is_adv && (bus.count_in < prev);
        // Clear applies before the increment, so clear + error yields 1.
        err_base = bus.clear_err ? '0 : bus.err_count;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            prev           <= '0;
            match_cnt      <= '0;
            bus.locked     <= 1'b0;
            bus.err_pulse  <= 1'b0;
            bus.err_count  <= '0;
            bus.wrap_count <= '0;
            bus.expected   <= STEP_W;
        end else begin
            bus.err_pulse <= err_now;

            if (err_now && (err_base != '1))
                bus.err_count <= err_base + CNT_W'(1);
            else
                bus.err_count <= err_base;

            if (wrap_now && (bus.wrap_count != '1))
                bus.wrap_count <= bus.wrap_count + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (!is_odd) begin
                        prev         <= bus.count_in;
                        bus.expected <= bus.count_in + STEP_W;
                        match_cnt    <= '0;
                        state        <= ACQUIRE;
                    end
                end

                ACQUIRE: begin
                    if (is_odd) begin
                        state <= IDLE;
                    end else if (is_adv) begin
                        prev         <= bus.count_in;
                        bus.expected <= bus.count_in + STEP_W;
                        match_cnt    <= match_cnt + 4'd1;
                        if ((match_cnt + 4'd1) == LOCK_W) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                        end
                    end else if (!is_hold) begin
                        prev         <= bus.count_in;
                        bus.expected <= bus.count_in + STEP_W;
                        match_cnt    <= '0;
                    end
                end

                LOCKED: begin
                    if (is_odd) begin
                        state      <= IDLE;
                        bus.locked <= 1'b0;
                    end else if (is_adv) begin
                        prev         <= bus.count_in;
                        bus.expected <= bus.count_in + STEP_W;
                    end else if (!is_hold) begin
                        prev         <= bus.count_in;
                        bus.expected <= bus.count_in + STEP_W;
                        match_cnt    <= '0;
                        state        <= ACQUIRE;
                        bus.locked   <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_even_count_checker.sv
// tb_even_count_checker: scoreboard bench for even_count_checker.
// Three instances: default parameters (a), CNT_W = 2 (b), ALLOW_HOLD = 0 (c).
// Stimulus drives on the falling edge and queues the hand-computed outputs
// expected after the next rising edge; a monitor pops and compares them.
module tb_even_count_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    even_count_checker_if #(.WIDTH(3), .CNT_W(8)) bus_a ();
    even_count_checker_if #(.WIDTH(3), .CNT_W(2)) bus_b ();
    even_count_checker_if #(.WIDTH(3), .CNT_W(8)) bus_c ();

    even_count_checker #(.WIDTH(3), .STEP(2), .LOCK_N(2), .ALLOW_HOLD(1), .CNT_W(8))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    even_count_checker #(.WIDTH(3), .STEP(2), .LOCK_N(2), .ALLOW_HOLD(1), .CNT_W(2))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    even_count_checker #(.WIDTH(3), .STEP(2), .LOCK_N(2), .ALLOW_HOLD(0), .CNT_W(8))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

    typedef struct {
        int id;
        int lk;
        int pl;
        int ec;
        int wc;
        int ex;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int id, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0d, required %0d", name, id, $time, act, req);
        end
    endtask

    // Drive one sample into the selected instance and queue its expected outputs.
    task automatic step(input int id, input logic rst, input logic [2:0] cin, input logic clr,
                        input int lk, input int pl, input int ec, input int wc, input int ex);
        exp_t e;
        @(negedge clk);
        reset = rst;
        case (id)
            0:       begin bus_a.count_in = cin; bus_a.clear_err = clr; end
            1:       begin bus_b.count_in = cin; bus_b.clear_err = clr; end
            default: begin bus_c.count_in = cin; bus_c.clear_err = clr; end
        endcase
        e.id = id; e.lk = lk; e.pl = pl; e.ec = ec; e.wc = wc; e.ex = ex;
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered, so sample just after each rising edge.
    initial begin
        exp_t e;
        int a_lk, a_pl, a_ec, a_wc, a_ex;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0: begin
                        a_lk = int'(bus_a.locked);     a_pl = int'(bus_a.err_pulse);
                        a_ec = int'(bus_a.err_count);  a_wc = int'(bus_a.wrap_count);
                        a_ex = int'(bus_a.expected);
                    end
                    1: begin
                        a_lk = int'(bus_b.locked);     a_pl = int'(bus_b.err_pulse);
                        a_ec = int'(bus_b.err_count);  a_wc = int'(bus_b.wrap_count);
                        a_ex = int'(bus_b.expected);
                    end
                    default: begin
                        a_lk = int'(bus_c.locked);     a_pl = int'(bus_c.err_pulse);
                        a_ec = int'(bus_c.err_count);  a_wc = int'(bus_c.wrap_count);
                        a_ex = int'(bus_c.expected);
                    end
                endcase
                chk("locked",     e.id, a_lk, e.lk);
                chk("err_pulse",  e.id, a_pl, e.pl);
                chk("err_count",  e.id, a_ec, e.ec);
                chk("wrap_count", e.id, a_wc, e.wc);
                chk("expected",   e.id, a_ex, e.ex);
            end
        end
    end

    initial begin
        int w;
        int wp;
        bus_a.count_in = '0; bus_a.clear_err = 1'b0;
        bus_b.count_in = '0; bus_b.clear_err = 1'b0;
        bus_c.count_in = '0; bus_c.clear_err = 1'b0;

        // ---- dut a: reset, hold, lock, wrap ----
        //     id rst cin clr  lk pl ec wc ex
        step(0, 0, 0, 0,   0, 0, 0, 0, 2);
        step(0, 1, 0, 0,   0, 0, 0, 0, 2);   // IDLE -> ACQUIRE
        step(0, 1, 0, 0,   0, 0, 0, 0, 2);   // legal hold
        step(0, 1, 2, 0,   0, 0, 0, 0, 4);
        step(0, 1, 4, 0,   1, 0, 0, 0, 6);   // second ADV locks
        step(0, 1, 6, 0,   1, 0, 0, 0, 0);
        step(0, 1, 0, 0,   1, 0, 0, 1, 2);   // 6 -> 0 wrap
        step(0, 1, 2, 0,   1, 0, 0, 1, 4);
        step(0, 1, 4, 0,   1, 0, 0, 1, 6);
        step(0, 1, 4, 0,   1, 0, 0, 1, 6);   // hold while locked
        // skip while locked
        step(0, 1, 0, 0,   0, 1, 1, 1, 2);
        step(0, 1, 2, 0,   0, 0, 1, 1, 4);
        step(0, 1, 4, 0,   1, 0, 1, 1, 6);
        // odd values in LOCKED, IDLE (back-to-back), ACQUIRE
        step(0, 1, 3, 0,   0, 1, 2, 1, 6);
        step(0, 1, 3, 0,   0, 1, 3, 1, 6);
        step(0, 1, 2, 0,   0, 0, 3, 1, 4);
        step(0, 1, 3, 0,   0, 1, 4, 1, 4);
        // clear without error, relock, build err_count = 2 while locked
        step(0, 1, 0, 1,   0, 0, 0, 1, 2);
        step(0, 1, 2, 0,   0, 0, 0, 1, 4);
        step(0, 1, 4, 0,   1, 0, 0, 1, 6);
        step(0, 1, 1, 0,   0, 1, 1, 1, 6);
        step(0, 1, 0, 0,   0, 0, 1, 1, 2);
        step(0, 1, 2, 0,   0, 0, 1, 1, 4);
        step(0, 1, 4, 0,   1, 0, 1, 1, 6);
        step(0, 1, 0, 0,   0, 1, 2, 1, 2);
        step(0, 1, 2, 0,   0, 0, 2, 1, 4);
        step(0, 1, 4, 0,   1, 0, 2, 1, 6);
        // mid-run reset with an odd sample and clear_err present
        step(0, 0, 3, 1,   0, 0, 0, 0, 2);
        step(0, 1, 0, 0,   0, 0, 0, 0, 2);
        step(0, 1, 2, 0,   0, 0, 0, 0, 4);
        step(0, 1, 4, 0,   1, 0, 0, 0, 6);

        // ---- dut b: CNT_W = 2 saturation and clear ----
        step(1, 0, 0, 0,   0, 0, 0, 0, 2);
        step(1, 1, 1, 0,   0, 1, 1, 0, 2);
        step(1, 1, 1, 0,   0, 1, 2, 0, 2);
        step(1, 1, 1, 0,   0, 1, 3, 0, 2);
        step(1, 1, 1, 0,   0, 1, 3, 0, 2);
        step(1, 1, 1, 0,   0, 1, 3, 0, 2);
        step(1, 1, 0, 0,   0, 0, 3, 0, 2);
        step(1, 1, 5, 1,   0, 1, 1, 0, 2);   // clear and error together
        step(1, 1, 0, 1,   0, 0, 0, 0, 2);
        step(1, 1, 2, 0,   0, 0, 0, 0, 4);
        step(1, 1, 4, 0,   1, 0, 0, 0, 6);
        for (int k = 1; k <= 4; k++) begin
            wp = (k - 1 > 3) ? 3 : k - 1;
            w  = (k > 3) ? 3 : k;
            step(1, 1, 6, 0,   1, 0, 0, wp, 0);
            step(1, 1, 0, 0,   1, 0, 0, w,  2);
            step(1, 1, 2, 0,   1, 0, 0, w,  4);
            step(1, 1, 4, 0,   1, 0, 0, w,  6);
        end

        // ---- dut c: ALLOW_HOLD = 0 ----
        step(2, 0, 0, 0,   0, 0, 0, 0, 2);
        step(2, 1, 0, 0,   0, 0, 0, 0, 2);
        step(2, 1, 2, 0,   0, 0, 0, 0, 4);
        step(2, 1, 4, 0,   1, 0, 0, 0, 6);
        step(2, 1, 4, 0,   0, 1, 1, 0, 6);   // repeat while locked is an error
        step(2, 1, 4, 0,   0, 0, 1, 0, 6);   // repeat in ACQUIRE resyncs silently
        step(2, 1, 6, 0,   0, 0, 1, 0, 0);
        step(2, 1, 0, 0,   1, 0, 1, 0, 2);   // wrap during ACQUIRE not counted
        step(2, 1, 0, 0,   0, 1, 2, 0, 2);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/even_count_checker.md
# even_count_checker

Downstream monitor for the even-counter stage. It samples the counter's `count` bus every cycle and checks that the bus follows the sequence 0, 2, 4, … (mod 2^WIDTH), with holds allowed. It reports lock status, flags each sequence violation with a one-cycle error pulse, and keeps saturating error and wrap-around counters for the status block.

## Interface
- `WIDTH`, default 3: width of the monitored count bus.
- `STEP`, default 2: expected increment per advancing sample; must be even and nonzero mod 2^WIDTH.
- `LOCK_N`, default 2: consecutive correct advancing samples needed to declare lock (1..15).
- `ALLOW_HOLD`, default 1: when 1, a sample equal to the previous sample is a legal stall; when 0, it is a mismatch.
- `CNT_W`, default 8: width of `err_count` and `wrap_count`.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low. When low at a rising edge, all state is cleared.
- `count_in` input WIDTH: count bus from the upstream even counter, sampled every cycle.
- `clear_err` input 1: synchronous clear of `err_count`.
- `locked` output 1: high while the FSM is in LOCKED.
- `err_pulse` output 1: one-cycle pulse for each detected violation.
- `err_count` output CNT_W: saturating count of violations.
- `wrap_count` output CNT_W: saturating count of wraps accepted in LOCKED.
- `expected` output WIDTH: next advancing value the checker expects, which is prev + STEP mod 2^WIDTH.

## Operation
- Registered state:
  - FSM state: IDLE, ACQUIRE or LOCKED.
  - `prev` (WIDTH bits): last accepted sample.
  - `match_cnt` (4 bits).
  - `err_count` and `wrap_count`.
- Reset values (`reset` = 0):
  - State = IDLE, `prev` = 0, `match_cnt` = 0.
  - `locked` = 0, `err_pulse` = 0, `err_count` = 0, `wrap_count` = 0.
  - `expected` = STEP mod 2^WIDTH.
- Sample classification, evaluated every cycle when `reset` = 1:
  - ODD: `count_in[0]` = 1.
  - ADV: `count_in` == `prev` + STEP (mod 2^WIDTH).
  - HOLD: `count_in` == `prev` and ALLOW_HOLD = 1.
  - BAD: anything else.
  - ODD takes priority over all other classes.
- IDLE:
  - Even sample: `prev` ← `count_in`, `match_cnt` ← 0, go to ACQUIRE.
  - ODD sample: `err_pulse`, stay in IDLE.
- ACQUIRE:
  - ADV: `prev` ← `count_in`, `match_cnt` += 1. If the new `match_cnt` == LOCK_N, go to LOCKED.
  - HOLD: no change.
  - BAD: resync, meaning `prev` ← `count_in` and `match_cnt` ← 0. No error is raised.
  - ODD: `err_pulse`, go to IDLE.
- LOCKED:
  - ADV: `prev` ← `count_in`. If `count_in` < `prev` (numeric wrap), `wrap_count` += 1.
  - HOLD: no change.
  - BAD: `err_pulse`, `prev` ← `count_in`, `match_cnt` ← 0, go to ACQUIRE.
  - ODD: `err_pulse`, go to IDLE.
- Every `err_pulse` increments `err_count`.
- Saturation: `err_count` and `wrap_count` stick at 2^CNT_W−1 and never wrap.
- `clear_err` = 1: `err_count` ← 0. If an error occurs in the same cycle, `err_count` ← 1 (clear first, then increment). `clear_err` does not affect FSM state, `wrap_count` or `locked`.
- `expected` always equals `prev` + STEP mod 2^WIDTH, computed in WIDTH bits with the carry discarded.
- The upstream counter holds 0 for one cycle after its reset releases. With ALLOW_HOLD = 1 that repeated 0 is a legal HOLD.

## Timing
- All outputs are registered; there is no combinational path from `count_in` to any output.
- `err_pulse`: high in the cycle after the edge that sampled the violating value, for exactly one cycle per violating sample. Back-to-back violations give back-to-back pulses.
- `locked`: rises at the edge that samples the LOCK_N-th consecutive ADV. It falls at the edge that samples a BAD or ODD value.
- Counter outputs reflect the new value immediately after the same edge.
- Reset mid-operation: at the first edge with `reset` = 0, all outputs go to their reset values, whatever the state, `clear_err` or `count_in`.
- Reset release: the first edge with `reset` = 1 samples `count_in` in IDLE.
- `count_in` is sampled every cycle; it has no valid qualifier.

## Test plan
- **Reset then lock** (default parameters): `count_in` = 0, 0, 2, 4, 6, 0, 2 after reset release.
  - HOLD at the second 0; `locked` = 1 after sampling 4.
  - `wrap_count` = 1 after sampling the final 0 (6→0).
  - `err_count` = 0 throughout.
- **Skip while locked**: after lock on 0, 2, 4, drive 0 (expected 6).
  - One `err_pulse`, `err_count` = 1, `locked` = 0, state ACQUIRE.
  - Then 2, 4 → `locked` = 1 again.
- **Odd value**: drive 3 in each state (IDLE, ACQUIRE, LOCKED).
  - Each gives exactly one `err_pulse` and a return to IDLE.
  - `err_count` = 3.
- **Saturation and clear** (CNT_W = 2):
  - Inject 5 violations → `err_count` = 3 and holds.
  - `clear_err` = 1 in a cycle that samples a violation → `err_count` = 1.
- **Mid-run reset**: while locked with `err_count` = 2, hold `reset` = 0 for one edge.
  - All outputs return to reset values; `expected` = 2.
  - Relock with 0, 2, 4.
- **No holds allowed** (ALLOW_HOLD = 0): after lock, repeat 4, 4.
  - `err_pulse` on the second 4; `locked` = 0.
